// File: rtl/vga_plot_framebuffer.sv
// Pixel-plot sink: stores plotted pixels in a WIDTH x HEIGHT framebuffer and
// streams it back out in raster order through a two-stage read pipeline.
module vga_plot_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    vga_x,
    input  logic [6:0]    vga_y,
    input  logic [CW-1:0] vga_colour,
    input  logic          vga_plot,
    input  logic          scan_en,
    output logic [7:0]    pix_x,
    output logic [6:0]    pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          pix_valid,
    output logic          frame_start,
    output logic          frame_done,
    output logic          plot_drop
);

    localparam int         DEPTH  = WIDTH * HEIGHT;
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    logic [CW-1:0] mem [DEPTH];

    logic          wr_ok;
    logic [AW-1:0] wr_addr;
    logic [7:0]    sx_p0;
    logic [6:0]    sy_p0;
    logic          run_p0;
    logic          rd_en_p0;
    logic [AW-1:0] rd_addr_p0;
    logic [CW-1:0] rd_data_p1;
    logic          rd_seen_p1;

    assign wr_ok      = (vga_x <= X_LAST) && (vga_y <= Y_LAST);
    assign wr_addr    = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
    assign rd_en_p0   = scan_en && run_p0;
    assign rd_addr_p0 = AW'(sy_p0) * AW'(WIDTH) + AW'(sx_p0);

    // Write and read ports kept in separate blocks so a simple dual-port RAM
    // is inferred; the read naturally returns the pre-write data.
    always_ff @(posedge clk) begin
        if (vga_plot && wr_ok)
            mem[wr_addr] <= vga_colour;
    end

    always_ff @(posedge clk) begin
        if (rd_en_p0)
            rd_data_p1 <= mem[rd_addr_p0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            plot_drop <= 1'b0;
        else
            plot_drop <= vga_plot && !wr_ok;
    end

    // Stage 0: scan counters. run_p0 holds off the first read for one cycle
    // after reset release so every output stays 0 through that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_p0  <= '0;
            sy_p0  <= '0;
            run_p0 <= 1'b0;
        end else begin
            run_p0 <= 1'b1;
            if (rd_en_p0) begin
                if (sx_p0 < X_LAST) begin
                    sx_p0 <= sx_p0 + 8'd1;
                end else begin
                    sx_p0 <= '0;
                    sy_p0 <= (sy_p0 == Y_LAST) ? '0 : sy_p0 + 7'd1;
                end
            end
        end
    end

    // Stage 1: registered pixel outputs aligned with the RAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            rd_seen_p1  <= 1'b0;
        end else begin
            pix_valid   <= rd_en_p0;
            frame_start <= rd_en_p0 && (sx_p0 == 8'd0) && (sy_p0 == 7'd0);
            frame_done  <= rd_en_p0 && (sx_p0 == X_LAST) && (sy_p0 == Y_LAST);
            if (rd_en_p0) begin
                pix_x      <= sx_p0;
                pix_y      <= sy_p0;
                rd_seen_p1 <= 1'b1;
            end
        end
    end

    // RAM data cannot be reset, so colour is masked until a post-reset read lands.
    assign pix_colour = rd_seen_p1 ? rd_data_p1 : '0;

endmodule

// File: doc/vga_plot_framebuffer.md
Name: vga_plot_framebuffer

Overview:
- Receiving end of the pixel-plot interface driven by fillscreen and the other drawing engines (`vga_x`/`vga_y`/`vga_colour`/`vga_plot`).
- Stores plotted pixels in an internal WIDTH×HEIGHT×CW dual-port framebuffer.
- Continuously scans the framebuffer out in raster order as a pixel stream for the display back end.
- Replaces the opaque adapter model in simulation and gives the drawing engines a checkable sink.

Parameters:
- WIDTH, 160, pixels per line (x range 0..WIDTH-1)
- HEIGHT, 120, lines per frame (y range 0..HEIGHT-1)
- CW, 3, colour bits per pixel

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous active-high reset
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  CW  plot colour
- vga_plot  in  1  write strobe; one pixel per cycle while high
- scan_en  in  1  scanout advance enable
- pix_x  out  8  x of current output pixel
- pix_y  out  7  y of current output pixel
- pix_colour  out  CW  colour read from framebuffer
- pix_valid  out  1  pix_* valid this cycle
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- frame_done  out  1  one-cycle pulse with pixel (WIDTH-1,HEIGHT-1)
- plot_drop  out  1  one-cycle pulse when a plot was out of range

Behaviour:
- Reset:
  - rst is asynchronous and active-high. All outputs read 0 while rst is high and in the cycle after release.
  - Scan counters are cleared to (0,0).
  - Framebuffer RAM contents are not reset; they are undefined until written.
- Write side:
  - On each rising edge with vga_plot=1, vga_x<WIDTH and vga_y<HEIGHT, mem[vga_y*WIDTH+vga_x] <= vga_colour.
  - Address is computed at full width with no truncation. There is no backpressure, so one write is accepted every cycle.
- Out-of-range plot (vga_x>=WIDTH or vga_y>=HEIGHT):
  - No write occurs.
  - plot_drop=1 on the next cycle, registered, one cycle per offending plot.
- Scan side (two-stage pipeline):
  - Stage 0: counters sx, sy. When scan_en=1, issue a read of mem[sy*WIDTH+sx] and advance:
    - sx+1 while sx<WIDTH-1.
    - Otherwise sx=0 and sy+1, or sy=0 when sy=HEIGHT-1 (wrap).
  - When scan_en=0 the counters hold and no read is issued.
  - Stage 1 (registered, 1-cycle latency):
    - pix_valid equals scan_en delayed one cycle.
    - pix_x and pix_y are the issued coordinates; pix_colour is the RAM read data.
    - frame_start = pix_valid && pix_x==0 && pix_y==0.
    - frame_done = pix_valid && pix_x==WIDTH-1 && pix_y==HEIGHT-1.
  - When pix_valid=0, pix_x, pix_y and pix_colour hold their last values; frame_start and frame_done are 0.
- Write/read collision:
  - Same address on the same edge: the read returns the old data (read-before-write).
  - The new value appears on the next scan of that pixel.
- Mid-operation reset:
  - Scan restarts from (0,0) and the in-flight pixel is discarded (pix_valid=0).
  - Framebuffer contents written before reset are retained.
- Scan order: row-major (x fastest). This differs from fillscreen's column-major write order, and the mismatch is intentional. Frame period at scan_en=1 is WIDTH*HEIGHT=19200 cycles.
- RAM is inferable as a simple dual-port block RAM: one write port, one read port, synchronous read.

Test Plan:
1. Reset values:
   - Assert rst asynchronously mid-cycle -> all outputs go to 0 immediately.
   - After release with scan_en=1 -> first pix_valid=1 two edges later at (0,0) with frame_start=1.
2. Single plot:
   - Write (5,7) colour 3'b101, then scan a full frame.
   - Required: pix_colour=3'b101 exactly when pix_x=5, pix_y=7.
   - Pixel (5,7) appears at output cycle 7*160+5=1125 after frame_start.
3. Full fill:
   - Drive a column-major fill with colour = x%8 over all 19200 pixels, then scan a frame.
   - Every pixel reads x%8; frame_done pulses once, at (159,119).
   - frame_start pulses again on the next valid cycle (wrap).
4. Out-of-range plots:
   - Plot (160,0), (0,120) and (255,127) -> three plot_drop pulses.
   - Pixels (0,0) and (159,119) retain their prior values.
5. Collision:
   - Plot colour 3'b111 to (10,0) on the same edge the scan issues (10,0), with a prior value of 3'b001.
   - Output shows 3'b001; the next frame shows 3'b111.
6. scan_en gating:
   - Toggle scan_en 1,0,0,1 around x=158..159 at y=119.
   - pix_valid follows with 1-cycle lag; coordinates are continuous with no skipped or duplicated pixels.
   - Wrap to (0,0) occurs correctly after the pause.
